bdiv40x20_iter: RTL and testbench
=================================

# bdiv40x20_iter

Iterative restoring divider, the inverse of the 20x20 bit-heap multiplier. It takes a 40-bit dividend `A` and a 20-bit divisor `B` and produces a 20-bit quotient `Q` and a 20-bit remainder `R`, resolving one quotient bit per clock. It sits beside the multiplier in the arithmetic library and recovers operands from products, e.g. for modular reduction and for checking multiplier results. Both ends use a valid/ready handshake.

## Interface
- `WIDTH`, default 20: divisor, quotient and remainder width. The dividend is 2*WIDTH bits.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: operands `A`/`B` are valid.
- `in_ready` out 1: the divider can accept operands.
- `A` in 2*WIDTH: dividend.
- `B` in WIDTH: divisor.
- `out_valid` out 1: the result is valid.
- `out_ready` in 1: the consumer takes the result.
- `Q` out WIDTH: quotient.
- `R` out WIDTH: remainder.
- `div_zero` out 1: `B` was 0.
- `ovf` out 1: the quotient does not fit, i.e. `A[2W-1:W] >= B` with `B != 0`.

## Operation
- States:
  - IDLE: `in_ready = 1`.
  - CALC: runs WIDTH steps.
  - DONE: `out_valid = 1`.
- `in_ready` and `out_valid` are decoded from the state register only. They have no combinational dependence on inputs.
- Accept happens when `in_valid & in_ready`. On accept:
  - Latch `A` and `B`.
  - Clear the step counter.
  - Set the partial remainder to `{1'b0, A[2W-1:W]}` (W+1 bits).
- Accept-time classification, with priority in this order:
  - `B == 0`: go to DONE with `div_zero = 1`, `Q = '1`, `R = A[W-1:0]`.
  - `A[2W-1:W] >= B`: go to DONE with `ovf = 1`, `Q = '1`, `R = A[W-1:0]`.
  - Otherwise: go to CALC with both flags 0.
- CALC step i (i = 0..W-1), taking dividend bits MSB-first from `A[W-1:0]`:
  - `t = {rem[W-1:0], A[W-1-i]}` (W+1 bits).
  - If `t >= {1'b0, B}`: `rem = t - B` and the quotient bit is 1. Otherwise `rem = t` and the quotient bit is 0.
  - Quotient bits shift into `Q` from the LSB.
- After step W-1, go to DONE with `R = rem[W-1:0]`.
- Invariants on every non-flagged result: `Q*B + R == A` and `R < B`.
- DONE holds `Q`, `R`, `div_zero` and `ovf` stable until `out_ready`. On `out_valid & out_ready` the state returns to IDLE.
- Inputs seen while `in_ready = 0` are ignored. `A` and `B` may change freely outside the accept cycle.
- `rst` overrides everything, including mid-CALC and DONE. The state goes to IDLE and any in-flight operation is discarded.

## Timing
- Reset values: state IDLE, `in_ready = 1`, `out_valid = 0`, `Q = 0`, `R = 0`, `div_zero = 0`, `ovf = 0`, step counter 0.
- Normal latency: accept at edge t gives `out_valid` high from edge t+W+1 (21 cycles at the default width).
- Flagged latency (`div_zero` or `ovf`): `out_valid` high from edge t+1.
- Throughput: `in_ready` returns high on the cycle after the output handshake. Minimum issue interval is W+2 cycles, or 2 cycles for a flagged operation.
- All outputs are registered.

## Configuration
- `BDIV_ZERO_SKIP_EN` defined:
  - An accepted dividend `A == 0` with `B != 0` goes directly to DONE with `Q = 0`, `R = 0` and flags 0. Latency is 1 cycle.
  - `div_zero` keeps priority over the skip.
- `BDIV_ZERO_SKIP_EN` undefined: `A == 0` runs the full CALC and gives `Q = 0`, `R = 0` at latency W+1.

## Structure
- Package `bdiv_pkg` contains:
  - `localparam BDIV_WIDTH = 20`.
  - `typedef enum logic [1:0] {IDLE, CALC, DONE} bdiv_state_t`.
  - The step-counter width, `$clog2(BDIV_WIDTH)`.
- Sub-module `bdiv_step` is purely combinational and is the single point for the step arithmetic.
  - Inputs: `rem`, `B`, next dividend bit.
  - Outputs: next `rem`, quotient bit.
- The top module `bdiv40x20_iter` holds the FSM, the counter and the operand/result registers.

## Test plan
- `A = 40'd100`, `B = 20'd7`, `out_ready = 1`: expect `Q = 14`, `R = 2`, flags 0, and `out_valid` exactly 21 cycles after accept.
- `A = 40'hFFFFEFFFFF`, `B = 20'hFFFFF`: expect `Q = 20'hFFFFF`, `R = 20'hFFFFE`, no `ovf`.
- `B = 0`, `A = 40'h12345_6789A`: expect `div_zero = 1`, `Q = 20'hFFFFF`, `R = 20'h6789A`, `out_valid` 1 cycle after accept.
- `A = 40'h00005_00000`, `B = 5`: expect `ovf = 1`, `div_zero = 0`, `Q = 20'hFFFFF`, `R = 0`.
- Backpressure: hold `out_ready = 0` for 5 cycles in DONE. Expect `Q`, `R` and flags stable and `in_ready = 0`; toggle `in_valid` and check nothing is accepted. Then take the result, and expect `in_ready = 1` on the next cycle.
- Reset mid-CALC: assert `rst` at step 10. Next cycle expect IDLE, `out_valid = 0`, `in_ready = 1`, all outputs 0. A fresh `100/7` then completes normally.
- With `BDIV_ZERO_SKIP_EN`: `A = 0`, `B = 3` gives `Q = 0`, `R = 0` at latency 1.

Source files
------------

// File: rtl/bdiv_pkg.sv
// bdiv_pkg: shared width, step-counter width and FSM state type for the iterative divider.
package bdiv_pkg;
    localparam int BDIV_WIDTH = 20;
    localparam int BDIV_CNT_W = $clog2(BDIV_WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, DONE} bdiv_state_t;
endpackage

// File: rtl/bdiv_step.sv
// bdiv_step: one combinational restoring-division step.
// Ports:
//   rem      in  WIDTH : partial remainder, always below B so its top bit is implied zero
//   B        in  WIDTH : divisor
//   din      in  1     : next dividend bit, MSB-first
//   rem_next out WIDTH : partial remainder after this step
//   qbit     out 1     : quotient bit produced by this step
module bdiv_step
    import bdiv_pkg::*;
#(
    parameter int WIDTH = BDIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] B,
    input  logic             din,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);
    logic [WIDTH:0] t;
    assign t = {rem, din};
    assign qbit = t >= {1'b0, B};
    // Either branch is below B, so the top bit is always zero and can be dropped.
    assign rem_next = WIDTH'(qbit ? t - {1'b0, B} : t);
endmodule

// File: rtl/bdiv40x20_iter.sv
// bdiv40x20_iter: iterative restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock.
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready high only in IDLE)
//   A [2W-1:0], B [W-1:0] : dividend and divisor, sampled on accept
//   out_valid, out_ready: result handshake (out_valid high only in DONE)
//   Q, R [W-1:0]        : quotient and remainder
//   div_zero, ovf       : divisor was zero / quotient does not fit in W bits
// Optional feature: define BDIV_ZERO_SKIP_EN to finish a zero dividend in one cycle.
module bdiv40x20_iter
    import bdiv_pkg::*;
#(
    parameter int WIDTH = BDIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Q,
    output logic [WIDTH-1:0]   R,
    output logic               div_zero,
    output logic               ovf
);
    localparam int CW = $clog2(WIDTH);

    bdiv_state_t      state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, dvd, dvs, rem_n;
    logic             qbit, accept, last, bz, hi_ge, skip;
    logic [WIDTH-1:0] hi, lo;

    assign hi = A[2*WIDTH-1:WIDTH];
    assign lo = A[WIDTH-1:0];
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign accept = in_valid & in_ready;
    assign last = cnt == CW'(WIDTH - 1);
    assign bz = B == '0;
    // With B == 0 this is trivially true, so div_zero masks it below.
    assign hi_ge = hi >= B;

`ifdef BDIV_ZERO_SKIP_EN
    assign skip = A == '0;
`else
    assign skip = 1'b0;
`endif

    bdiv_step #(.WIDTH(WIDTH)) u_step (
        .rem(rem),
        .B(dvs),
        .din(dvd[WIDTH-1]),
        .rem_next(rem_n),
        .qbit(qbit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (in_valid ? ((bz | hi_ge | skip) ? DONE : CALC) : IDLE)
                : state == CALC ? (last ? DONE : CALC)
                : state == DONE ? (out_ready ? IDLE : DONE)
                : IDLE;
    end

    // A skipped zero dividend needs no special data path: Q and R already clear to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            rem <= '0;
            dvd <= '0;
            dvs <= '0;
            Q <= '0;
            R <= '0;
            div_zero <= 1'b0;
            ovf <= 1'b0;
        end else if (accept) begin
            cnt <= '0;
            rem <= hi;
            dvd <= lo;
            dvs <= B;
            Q <= (bz | hi_ge) ? '1 : '0;
            R <= (bz | hi_ge) ? lo : '0;
            div_zero <= bz;
            ovf <= ~bz & hi_ge;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            rem <= rem_n;
            dvd <= {dvd[WIDTH-2:0], 1'b0};
            Q <= {Q[WIDTH-2:0], qbit};
            if (last) R <= rem_n;
        end
    end
endmodule

// File: tb/tb_bdiv40x20_iter.sv
// tb_bdiv40x20_iter: directed and randomized checks of bdiv40x20_iter against an arithmetic model.
module tb_bdiv40x20_iter;
    localparam int W = 20;
`ifdef BDIV_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2*W-1:0] A = '0;
    logic [W-1:0]  B = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  Q, R;
    logic          div_zero, ovf;
    int            checks = 0;
    int            errors = 0;

    bdiv40x20_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .Q(Q), .R(R), .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [2*W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov, output int lat);
        longint unsigned aa = 64'(a);
        longint unsigned bb = 64'(b);
        dz = b == '0;
        ov = 1'b0;
        if (bb == 0) begin
            q = '1; r = a[W-1:0]; lat = 1;
        end else if (aa / bb > 64'hFFFFF) begin
            ov = 1'b1; q = '1; r = a[W-1:0]; lat = 1;
        end else begin
            q = W'(aa / bb); r = W'(aa % bb);
            lat = (SKIP && a == '0) ? 1 : W + 1;
        end
    endfunction

    task automatic run_op(input logic [2*W-1:0] a, input logic [W-1:0] b, output int lat);
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A = 40'({$urandom, $urandom});
        B = 20'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, Q, R, div_zero, ovf} !== {1'b1, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b Q=%h R=%h dz=%b ovf=%b, want rdy=1 vld=0 rest 0",
                     in_ready, out_valid, Q, R, div_zero, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_vector(input string name, input logic [2*W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq, er;
        logic edz, eov;
        int elat, lat;
        model(a, b, eq, er, edz, eov, elat);
        run_op(a, b, lat);
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
        end
        checks++;
        if ({Q, R, div_zero, ovf} !== {eq, er, edz, eov}) begin
            errors++;
            $display("FAIL %s result: got Q=%h R=%h dz=%b ovf=%b want Q=%h R=%h dz=%b ovf=%b",
                     name, Q, R, div_zero, ovf, eq, er, edz, eov);
        end
        consume();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s release: got rdy=%b vld=%b want rdy=1 vld=0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_directed();
        test_vector("div_100_7", 40'd100, 20'd7);
        test_vector("div_max", 40'hFFFFEFFFFF, 20'hFFFFF);
        test_vector("div_zero", 40'h123456789A, 20'd0);
        test_vector("ovf", 40'h0000500000, 20'd5);
        test_vector("ovf_edge", 40'h0000700000, 20'd7);
        test_vector("below_ovf", 40'h00006FFFFF, 20'd7);
        test_vector("a_zero", 40'd0, 20'd3);
        test_vector("div_one", 40'h00000ABCDE, 20'd1);
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        run_op(40'd100, 20'd7, lat);
        checks++;
        if (lat !== W + 1) begin
            errors++;
            $display("FAIL bp latency: got %0d want %0d", lat, W + 1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = i[0];
            A = 40'({$urandom, $urandom});
            B = 20'($urandom_range(1, 15));
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, Q, R, div_zero, ovf} !== {1'b1, 1'b0, 20'd14, 20'd2, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp hold %0d: vld=%b rdy=%b Q=%h R=%h dz=%b ovf=%b want vld=1 rdy=0 Q=e R=2",
                         i, out_valid, in_ready, Q, R, div_zero, ovf);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
        end
        test_vector("bp_after", 40'd100, 20'd7);
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        A = 40'd100; B = 20'd7; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, Q, R, div_zero, ovf} !== {1'b1, 1'b0, 20'd0, 20'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid: rdy=%b vld=%b Q=%h R=%h dz=%b ovf=%b want rdy=1 vld=0 rest 0",
                     in_ready, out_valid, Q, R, div_zero, ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        test_vector("rst_after", 40'd100, 20'd7);
    endtask

    task automatic test_random();
        logic [W-1:0] b, hi;
        int mode;
        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 9));
            b = mode < 4 ? 20'($urandom_range(1, 255)) : 20'($urandom_range(1, 20'hFFFFF));
            if (mode == 0) b = '0;
            hi = (mode == 1) ? 20'($urandom_range(int'(b), 20'hFFFFF)) : (b == '0 ? 20'($urandom) : 20'($urandom % b));
            test_vector($sformatf("rand%0d", n), {hi, 20'($urandom)}, b);
        end
    endtask

    task automatic test_back_to_back(input string name, input logic [2*W-1:0] a, input logic [W-1:0] b,
                                     input int gap);
        int t = 0, first = -1, second = -1;
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        while (second < 0 && t < 200) begin
            @(negedge clk);
            if (in_ready) begin
                if (first < 0) first = t;
                else second = t;
            end
            t++;
        end
        checks++;
        if (second - first !== gap) begin
            errors++;
            $display("FAIL %s interval: got %0d want %0d", name, second - first, gap);
        end
        in_valid = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        test_back_to_back("b2b_normal", 40'd100, 20'd7, W + 2);
        test_back_to_back("b2b_flag", 40'd100, 20'd0, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
